// File: rtl/ser_wordasm_pkg.sv
// ser_wordasm_pkg: shared serial-path widths, defaults and assembler state type.
package ser_wordasm_pkg;
    localparam int BYTE_W         = 8;
    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = 4;
    localparam int DEF_DEPTH      = 16;
    localparam int DEF_TIMEOUT    = 1000000;
    typedef enum logic {COLLECT, OUT} asm_state_e;
endpackage

// File: rtl/ser_wordasm_if.sv
// ser_wordasm_if: receiver-side byte strobe, command-word handshake and status of the word assembler.
interface ser_wordasm_if
    import ser_wordasm_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH
);
    localparam int LW = $clog2(DEPTH + 1);
    logic              rcv_full;
    logic [BYTE_W-1:0] rcv_data;
    logic              word_valid;
    logic              word_ready;
    logic [WORD_W-1:0] word_data;
    logic [LW-1:0]     level;
    logic              overflow;
    logic              frame_err;
    logic              err_clr;
    modport master (
        output rcv_full, rcv_data, word_ready, err_clr,
        input  word_valid, word_data, level, overflow, frame_err
    );
    modport slave (
        input  rcv_full, rcv_data, word_ready, err_clr,
        output word_valid, word_data, level, overflow, frame_err
    );
endinterface

// File: rtl/ser_fifo.sv
// ser_fifo: synchronous FIFO with explicit occupancy count; a push is accepted when full if a pop happens in the same cycle.
module ser_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic [W-1:0]               din_i,
    input  logic                       pop_i,
    output logic [W-1:0]               dout_o,
    output logic [$clog2(DEPTH+1)-1:0] level_o,
    output logic                       full_o,
    output logic                       empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [LW-1:0] level_q, level_d;
    logic          wr_en, rd_en;
    always_comb begin
        full_o  = level_q == LW'(DEPTH);
        empty_o = level_q == '0;
        rd_en   = pop_i && !empty_o;
        wr_en   = push_i && (!full_o || rd_en);
        wr_d    = wr_en ? wr_q + 1'b1 : wr_q;
        rd_d    = rd_en ? rd_q + 1'b1 : rd_q;
        level_d = level_q + LW'(wr_en) - LW'(rd_en);
        dout_o  = mem[rd_q];
        level_o = level_q;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            level_q <= level_d;
        end
    end
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_q] <= din_i;
    end
endmodule

// File: rtl/ser_wordasm.sv
// ser_wordasm: buffers received bytes, packs them little-endian into 32-bit command words,
// flags dropped bytes and discards partial words after a line-idle timeout.
module ser_wordasm
    import ser_wordasm_pkg::*;
#(
    parameter int DEPTH   = DEF_DEPTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input logic          clk,
    input logic          reset,
    ser_wordasm_if.slave bus
);
    localparam int IW = $clog2(BYTES_PER_WORD);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int LW = $clog2(DEPTH + 1);
    localparam logic [IW-1:0] LAST = IW'(BYTES_PER_WORD - 1);
    asm_state_e                            state_q, state_d;
    logic [IW-1:0]                         idx_q, idx_d;
    logic [BYTES_PER_WORD-2:0][BYTE_W-1:0] lanes_q, lanes_d;
    logic [WORD_W-1:0]                     word_q, word_d;
    logic [CW-1:0]                         cnt_q, cnt_d;
    logic                                  ovf_q, ovf_d, ferr_q, ferr_d;
    logic                                  pop, idle, tmo, drop, full, empty;
    logic [BYTE_W-1:0]                     head;
    logic [LW-1:0]                         level;
    ser_fifo #(.DEPTH(DEPTH), .W(BYTE_W)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (bus.rcv_full),
        .din_i   (bus.rcv_data),
        .pop_i   (pop),
        .dout_o  (head),
        .level_o (level),
        .full_o  (full),
        .empty_o (empty)
    );
    always_comb begin
        pop     = state_q == COLLECT && !empty;
        idle    = state_q == COLLECT && idx_q != '0 && empty;
        tmo     = idle && cnt_q == CW'(TIMEOUT - 1);
        drop    = bus.rcv_full && full && !pop;
        state_d = state_q;
        idx_d   = idx_q;
        lanes_d = lanes_q;
        word_d  = word_q;
        // The last byte goes straight into the output word, so only BYTES_PER_WORD-1 lanes are stored.
        if (pop && idx_q == LAST) begin
            state_d = OUT;
            idx_d   = '0;
            word_d  = {head, lanes_q};
        end else if (pop) begin
            lanes_d[idx_q] = head;
            idx_d          = idx_q + 1'b1;
        end else if (tmo) begin
            idx_d   = '0;
            lanes_d = '0;
        end else if (state_q == OUT && bus.word_ready) begin
            state_d = COLLECT;
        end
        cnt_d  = idle && !tmo ? cnt_q + 1'b1 : '0;
        ovf_d  = drop || (ovf_q && !bus.err_clr);
        ferr_d = tmo || (ferr_q && !bus.err_clr);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= COLLECT;
            idx_q   <= '0;
            lanes_q <= '0;
            word_q  <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            lanes_q <= lanes_d;
            word_q  <= word_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            ferr_q  <= ferr_d;
        end
    end
    assign bus.word_valid = state_q == OUT;
    assign bus.word_data  = word_q;
    assign bus.level      = level;
    assign bus.overflow   = ovf_q;
    assign bus.frame_err  = ferr_q;
endmodule
